// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives bytes addressed to OWN_ADDR into a small FIFO.
// Reads are NACKed; a full FIFO NACKs the byte and flags overflow.
module i2c_target_rx #(
    parameter logic [6:0] OWN_ADDR    = 7'h42,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       stop_det,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       busy
);

    // state      | meaning
    // S_IDLE     | bus free or not yet framed; wait for START
    // S_ADDR     | shifting in address + R/W bit
    // S_ADDR_ACK | decide match; ACK on the 9th clock if matched
    // S_DATA     | shifting in a data byte
    // S_DATA_ACK | push byte (or NACK on full); ACK on the 9th clock
    // S_IGNORE   | not for us / overflowed; wait for START or STOP
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] PH_DECIDE = 2'd0;
    localparam logic [1:0] PH_WAIT   = 2'd1;
    localparam logic [1:0] PH_DRIVE  = 2'd2;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_dly_q, sda_dly_q;
    logic                   s_scl, s_sda;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_dly_q  <= s_scl;
            sda_dly_q  <= s_sda;
        end
    end

    assign s_scl    = scl_sync_q[SYNC_STAGES-1];
    assign s_sda    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = s_scl & ~scl_dly_q;
    assign scl_fall = ~s_scl & scl_dly_q;
    assign start_ev = s_scl & sda_dly_q & ~s_sda;
    assign stop_ev  = s_scl & ~sda_dly_q & s_sda;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  phase_q, phase_d;
    logic        busy_q, busy_d;
    logic        first_q, first_d;
    logic        sda_oe_q, sda_oe_d;
    logic        stop_q, stop_d;
    logic        ovf_q;
    logic        push, pop, ovf_set, full, addr_match;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;

    assign full       = (count_q == FULL_CNT);
    assign addr_match = (shift_q[7:1] == OWN_ADDR) && !shift_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd7;
            shift_q  <= 8'h00;
            phase_q  <= PH_DECIDE;
            busy_q   <= 1'b0;
            first_q  <= 1'b0;
            sda_oe_q <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            first_q  <= first_d;
            sda_oe_q <= sda_oe_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        phase_d  = phase_q;
        busy_d   = busy_q;
        first_d  = first_q;
        sda_oe_d = sda_oe_q;
        stop_d   = 1'b0;
        push     = 1'b0;
        ovf_set  = 1'b0;

        if (start_ev) begin
            state_d  = S_ADDR;
            cnt_d    = 3'd7;
            shift_d  = 8'h00;
            phase_d  = PH_DECIDE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = S_IDLE;
            phase_d  = PH_DECIDE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            stop_d   = busy_q;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], s_sda};
                        if (cnt_q == 3'd0) begin
                            state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                            phase_d = PH_DECIDE;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    case (phase_q)
                        PH_DECIDE: begin
                            // Evaluated exactly once per byte, the cycle after the 8th rise.
                            if (state_q == S_ADDR_ACK) begin
                                if (addr_match) begin
                                    busy_d  = 1'b1;
                                    first_d = 1'b1;
                                end
                            end else if (!full) begin
                                push    = 1'b1;
                                first_d = 1'b0;
                            end else begin
                                ovf_set = 1'b1;
                            end
                            if ((state_q == S_ADDR_ACK) ? !addr_match : full) begin
                                state_d = S_IGNORE;
                            end else if (scl_fall) begin
                                phase_d  = PH_DRIVE;
                                sda_oe_d = 1'b1;
                            end else begin
                                phase_d = PH_WAIT;
                            end
                        end
                        PH_WAIT: begin
                            if (scl_fall) begin
                                phase_d  = PH_DRIVE;
                                sda_oe_d = 1'b1;
                            end
                        end
                        default: begin
                            if (scl_fall) begin
                                sda_oe_d = 1'b0;
                                phase_d  = PH_DECIDE;
                                state_d  = S_DATA;
                                cnt_d    = 3'd7;
                                shift_d  = 8'h00;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign pop = rx_valid & rx_ready;

    // Storage is not reset; the head is masked by rx_valid instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {first_q, shift_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign rx_valid = (count_q != '0);
    assign rx_data  = rx_valid ? mem_q[rptr_q][7:0] : 8'h00;
    assign rx_first = rx_valid ? mem_q[rptr_q][8] : 1'b0;
    assign sda_oe   = sda_oe_q;
    assign stop_det = stop_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: directed frames plus random frames checked against
// a byte-level model of which bytes get ACKed and what the FIFO should deliver.
module tb_i2c_target_rx;

    localparam logic [6:0] OWN   = 7'h42;
    localparam int         DEPTH = 4;
    localparam int         Q     = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_first, rx_valid, stop_det, overflow, busy;
    logic       rx_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target_rx #(.OWN_ADDR(OWN), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_drv), .sda_i(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .stop_det(stop_det), .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // bus-side monitors
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int  stop_cnt = 0, oe_cnt = 0, stable_viol = 0, oe_bit_bad = 0;
    logic       hold_prev = 1'b0;
    logic [8:0] head_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (stop_det) stop_cnt++;
            if (sda_oe) oe_cnt++;
            if (hold_prev && ({rx_first, rx_data} != head_prev)) stable_viol++;
            if (rx_valid && rx_ready) got_q.push_back({rx_first, rx_data});
            hold_prev = rx_valid & !rx_ready;
            head_prev = {rx_first, rx_data};
        end
    end

    // reference model state
    logic [7:0] fdata [0:7];
    int   m_occ = 0;
    logic m_ovf = 1'b0;
    logic last_match = 1'b0;
    int   stop_base = 0;

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wait_q();
        scl_drv = 1'b1; wait_q();
        if (sda_oe) oe_bit_bad++;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        acked = sda_oe;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic do_frame(input logic [7:0] addr, input int n, input logic rdy);
        logic a, exp_a, ign, first;
        int   oe_base;
        rx_ready = rdy;
        oe_base  = oe_cnt;
        bus_start();
        send_byte(addr, a);
        exp_a = (addr[7:1] == OWN) && !addr[0];
        check("addr_ack", a, exp_a);
        check("busy", busy, exp_a);
        last_match = exp_a;
        ign   = !exp_a;
        first = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_byte(fdata[i], a);
            if (ign) begin
                exp_a = 1'b0;
            end else if (!rdy && m_occ == DEPTH) begin
                exp_a = 1'b0;
                ign   = 1'b1;
                m_ovf = 1'b1;
            end else begin
                exp_a = 1'b1;
                exp_q.push_back({first, fdata[i]});
                first = 1'b0;
                if (!rdy) m_occ++;
            end
            check("data_ack", a, exp_a);
        end
        if (!last_match) check("oe_quiet", oe_cnt - oe_base, 0);
        check("oe_in_bits", oe_bit_bad, 0);
    endtask

    task automatic finish_frame();
        bus_stop();
        check("stop_det", stop_cnt - stop_base, {31'd0, last_match});
        check("busy_after_stop", busy, 0);
        check("overflow", overflow, m_ovf);
        if (m_ovf) begin
            ovf_clr = 1'b1; @(posedge clk); #1;
            ovf_clr = 1'b0; @(posedge clk); #1;
            check("ovf_clr", overflow, 0);
            m_ovf = 1'b0;
        end
        check("stable_head", stable_viol, 0);
        rx_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && rx_valid; k++) begin
            @(posedge clk); #1;
        end
        check("drained", rx_valid, 0);
        repeat (2) @(posedge clk); #1;
        m_occ = 0;
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check("rx_missing", exp_q.size(), 0);
                exp_q.delete();
            end else begin
                check("rx_entry", got_q.pop_front(), exp_q.pop_front());
            end
        end
        check("rx_extra", got_q.size(), 0);
        got_q.delete();
        stop_base = stop_cnt;
    endtask

    initial begin
        logic a;
        int   nf;
        logic [7:0] ad;

        repeat (3) @(posedge clk); #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        wait_q();

        // basic write, consumer always ready
        fdata[0] = 8'hA5; fdata[1] = 8'h3C;
        do_frame(8'h84, 2, 1'b1);
        finish_frame();

        // wrong address
        fdata[0] = 8'h11;
        do_frame(8'h86, 1, 1'b1);
        finish_frame();

        // read request
        do_frame(8'h85, 0, 1'b1);
        finish_frame();

        // overflow on the fifth byte
        for (int i = 0; i < 5; i++) fdata[i] = 8'(i + 1);
        do_frame(8'h84, 5, 1'b0);
        finish_frame();

        // repeated START gives a second first-byte
        fdata[0] = 8'h10;
        do_frame(8'h84, 1, 1'b1);
        fdata[0] = 8'h20;
        do_frame(8'h84, 1, 1'b1);
        finish_frame();

        // reset in the middle of a data byte
        rx_ready = 1'b0;
        bus_start();
        send_byte(8'h84, a);
        send_byte(8'h55, a);
        check("pre_rst_valid", rx_valid, 1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; repeat (3) @(posedge clk); #1;
        rst = 1'b1; #1;
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_first", rx_first, 0);
        check("mid_rst_stop", stop_det, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        exp_q.delete(); got_q.delete();
        m_occ = 0; last_match = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        scl_drv = 1'b0; wait_q();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        stop_base = stop_cnt;
        fdata[0] = 8'h77;
        do_frame(8'h84, 1, 1'b1);
        finish_frame();

        // random frames, some chained with repeated START
        for (int f = 0; f < 16; f++) begin
            logic rdy;
            rdy = 1'($urandom_range(0, 1));
            nf  = $urandom_range(1, 2);
            for (int c = 0; c < nf; c++) begin
                case ($urandom_range(0, 3))
                    0, 1:    ad = {OWN, 1'b0};
                    2:       ad = {OWN, 1'b1};
                    default: begin
                        ad = 8'($urandom);
                        if (ad[7:1] == OWN) ad[7:1] = ~OWN;
                    end
                endcase
                for (int i = 0; i < 6; i++) fdata[i] = 8'($urandom);
                do_frame(ad, $urandom_range(0, 6), rdy);
            end
            finish_frame();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface — parameters
REQ-001 SHALL have parameter OWN_ADDR, default 7'h42: 7-bit target address answered by the block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries; a power of 2, minimum 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on scl_i and sda_i; minimum 2.

Interface — ports
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port scl_i, input, 1: bus SCL level, asynchronous to clk.
REQ-007 SHALL have port sda_i, input, 1: bus SDA level, asynchronous to clk.
REQ-008 SHALL have port sda_oe, output, 1: 1 pulls SDA low (open-drain); 0 releases.
REQ-009 SHALL have port rx_data, output, 8: FIFO head byte.
REQ-010 SHALL have port rx_first, output, 1: FIFO head is the first data byte after an address phase.
REQ-011 SHALL have port rx_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port rx_ready, input, 1: consumer pops head when rx_valid & rx_ready.
REQ-013 SHALL have port stop_det, output, 1: one-cycle pulse on STOP while addressed.
REQ-014 SHALL have port overflow, output, 1: sticky; set when a byte is NACKed for FIFO full.
REQ-015 SHALL have port ovf_clr, input, 1: synchronous clear of overflow.
REQ-016 SHALL have port busy, output, 1: 1 between an address match and the following STOP/START.

Function
REQ-017 SHALL synchronise scl_i/sda_i through SYNC_STAGES flops; all edges use synchronised values (s_scl, s_sda) and their 1-cycle-delayed copies.
REQ-018 SHALL detect START as s_sda 1->0 while s_scl=1, and STOP as s_sda 0->1 while s_scl=1, in any state.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-020 START (incl. repeated START) -> ADDR with bit counter=7 and shift register cleared, from any state.
REQ-021 STOP -> IDLE from any state; pulse stop_det if busy was 1.
REQ-022 ADDR/DATA: shift s_sda in MSB first on each s_scl rising edge; after the 8th bit -> ADDR_ACK/DATA_ACK respectively.
REQ-023 ADDR match: shift[7:1]==OWN_ADDR and shift[0]==0 (write) -> ACK; busy=1; next data byte flagged first.
REQ-024 ADDR mismatch or R/W=1 (read unsupported) -> NACK (sda_oe stays 0), then IGNORE until START/STOP.
REQ-025 DATA_ACK: if FIFO not full, push {first, byte} in the cycle after the 8th s_scl rise and ACK; if full, drop byte, NACK, set overflow, -> IGNORE.
REQ-026 ACK drive: sda_oe=1 from the first s_scl falling edge after bit 8 until the next s_scl falling edge (9th clock); then release, -> DATA with counter=7.
REQ-027 sda_oe SHALL be 0 in IDLE, ADDR, DATA, IGNORE, and during any NACK.
REQ-028 FIFO: rx_valid=1 when count>0; pointers wrap modulo FIFO_DEPTH; simultaneous push and pop when full is not possible (push requires not full); simultaneous push and pop when empty SHALL push only, count +1.
REQ-029 Simultaneous push and pop when non-empty and not full SHALL keep count unchanged.
REQ-030 rx_data/rx_first SHALL be stable while rx_valid & !rx_ready.
REQ-031 overflow set takes priority over ovf_clr in the same cycle.
REQ-032 No bus clock stretching; SCL is never driven.

Reset
REQ-033 rst=1 SHALL asynchronously force: state IDLE, sda_oe=0, FIFO empty (rx_valid=0), rx_data=0, rx_first=0, stop_det=0, overflow=0, busy=0, synchronisers=1.
REQ-034 Reset mid-transfer SHALL drop partial byte and FIFO contents; after release, block waits for a fresh START.

Verification
REQ-035 START, 0x84 (0x42 write), 0xA5, 0x3C, STOP, rx_ready=1 -> ACK on 3 ninth-clocks; rx_data 0xA5 (first=1), 0x3C (first=0); stop_det one pulse.
REQ-036 START, 0x86 (0x43 write), 0x11, STOP -> no ACK, sda_oe never 1, rx_valid stays 0, no stop_det.
REQ-037 START, 0x85 (read), STOP -> NACK, IGNORE, rx_valid 0.
REQ-038 FIFO_DEPTH=4, rx_ready=0, write 5 bytes 0x01..0x05 -> first 4 ACKed, 5th NACKed, overflow=1; drain gives 0x01..0x04; ovf_clr clears overflow.
REQ-039 START, 0x84, 0x10, repeated START, 0x84, 0x20, STOP -> 0x10 and 0x20 both first=1.
REQ-040 Assert rst during bit 4 of a data byte -> all outputs at reset values immediately; subsequent complete 0x84/0x77 frame received correctly.
